// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_unit_pkg                                                        |
// | Shared load/store size codes, FSM state encoding and alignment helper.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_access_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_GNT  = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return (addr_lo != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_unit_if                                                         |
// | req/gnt/rvalid data-memory bus between the load/store unit and memory.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH/8-1:0] mem_be;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    mem_gnt;
    logic                    mem_rvalid;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_lane_align                                                             |
// | Byte enables, store-data lane replication, misalign detect, load shift.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lsu_lane_align
    import mem_access_unit_pkg::*;
(
    input  wire logic [2:0]  i_funct3,
    input  wire logic [1:0]  i_addr_lo,
    input  wire logic        i_is_store,
    input  wire logic [31:0] i_wdata,
    input  wire logic [1:0]  i_rd_shift,
    input  wire logic [31:0] i_rdata,
    output logic      [3:0]  o_be,
    output logic      [31:0] o_wdata,
    output logic             o_misaligned,
    output logic      [31:0] o_rdata
);

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        if (i_is_store) begin
            case (i_funct3)
                F3_B, F3_BU: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                F3_H, F3_HU: begin
                    o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
                    o_wdata = {2{i_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    assign o_misaligned = is_misaligned(i_funct3, i_addr_lo);
    // Addressed byte/half lands in bit 0; extension happens downstream.
    assign o_rdata      = i_rdata >> {i_rd_shift, 3'b000};

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_unit                                                            |
// | MEM-stage load/store unit: one bus access per load/store, stalls the pipe. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int FUNCT3_WIDTH = 3
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    MemRead_M,
    input  wire logic                    MemWrite_M,
    input  wire logic [FUNCT3_WIDTH-1:0] funct3_M,
    input  wire logic [ADDR_WIDTH-1:0]   calc_result_M,
    input  wire logic [DATA_WIDTH-1:0]   WriteData_M,
    output logic      [DATA_WIDTH-1:0]   ReadData_M,
    output logic                         stall_M,
    output logic                         misaligned_M,
    mem_access_unit_if.master            bus
);

    lsu_state_e            state_q, state_d;
    logic [1:0]            addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  w_mem_op;
    logic                  w_misaligned;
    logic                  w_acc;
    logic                  w_req;
    logic                  w_stall;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rdata_shifted;

    lsu_lane_align u_lane_align (
        .i_funct3     (funct3_M),
        .i_addr_lo    (calc_result_M[1:0]),
        .i_is_store   (MemWrite_M),
        .i_wdata      (WriteData_M),
        .i_rd_shift   (addr_q),
        .i_rdata      (bus.mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_misaligned (w_misaligned),
        .o_rdata      (w_rdata_shifted)
    );

    assign w_mem_op = MemRead_M | MemWrite_M;
    assign w_acc    = w_mem_op & ~w_misaligned;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        w_req   = 1'b0;
        w_stall = 1'b0;
        case (state_q)
            IDLE: begin
                w_req   = w_acc;
                w_stall = w_acc;
                if (w_acc) begin
                    addr_d  = calc_result_M[1:0];
                    we_d    = MemWrite_M;
                    state_d = bus.mem_gnt ? WAIT_RESP : WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
                if (bus.mem_gnt) state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                w_stall = 1'b1;
                if (bus.mem_rvalid) begin
                    rdata_d = we_q ? '0 : w_rdata_shifted;
                    state_d = DONE;
                end
            end
            // Unconditional return: the next memory op needs a fresh IDLE cycle.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 2'b00;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    // Gate with rst_n so no request or stall escapes while reset is held.
    assign bus.mem_req   = w_req & rst_n;
    assign stall_M       = w_stall & rst_n;
    assign misaligned_M  = w_mem_op & w_misaligned & (state_q == IDLE);
    assign ReadData_M    = (state_q == DONE) ? rdata_q : '0;

    assign bus.mem_we    = MemWrite_M;
    assign bus.mem_addr  = {calc_result_M[ADDR_WIDTH-1:2], 2'b00};
    assign bus.mem_be    = w_be;
    assign bus.mem_wdata = w_wdata;

endmodule
`default_nettype wire
